// File: rtl/x_uart_link.sv
// x_uart_link: parametrised UART transmitter and receiver with an RX FIFO.
//   TX: i_data/i_valid/o_accept handshake in, serial o_tx out (idle high).
//   RX: samples internal TX line (i_loop=1) or i_rx (i_loop=0) through a
//       2-flop synchroniser; completed words, with parity/framing error
//       flags, are pushed into a p_depth-entry FIFO.
//   FIFO: o_valid/o_data/o_perr/o_ferr head, popped by i_ready; o_overflow
//       pulses when a completed frame is dropped; o_level is the occupancy.
module x_uart_link #(
  parameter int unsigned p_clk_hz    = 1000000,
  parameter int unsigned p_baud      = 115200,
  parameter int unsigned p_data_bits = 8,
  parameter int unsigned p_parity    = 0,
  parameter int unsigned p_stop_bits = 1,
  parameter int unsigned p_depth     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_loop,
  input  logic [p_data_bits-1:0]   i_data,
  input  logic                     i_valid,
  output logic                     o_accept,
  output logic                     o_tx,
  input  logic                     i_rx,
  output logic                     o_valid,
  output logic [p_data_bits-1:0]   o_data,
  output logic                     o_perr,
  output logic                     o_ferr,
  input  logic                     i_ready,
  output logic                     o_overflow,
  output logic [$clog2(p_depth):0] o_level
);

  localparam int unsigned CPB = p_clk_hz / p_baud;
  localparam int unsigned CW  = $clog2(CPB);
  localparam int unsigned BW  = 4;
  localparam int unsigned AW  = $clog2(p_depth);
  localparam int unsigned FW  = p_data_bits + 2;

  if (CPB < 4) begin : g_bad_cpb
    $error("x_uart_link: clocks per bit must be at least 4");
  end

  // ---------------- TX ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  tx_state_e               tx_state_q, tx_state_d;
  logic [CW-1:0]           tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]           tx_bit_q, tx_bit_d;
  logic [p_data_bits-1:0]  tx_shift_q, tx_shift_d;
  logic                    tx_par_q, tx_par_d;
  logic                    tx_tick;
  logic                    tx_line;

  assign tx_tick = (tx_cnt_q == CW'(CPB - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (i_valid) begin
          tx_state_d = TX_START;
          tx_shift_d = i_data;
          tx_par_d   = (p_parity == 2) ? ~^i_data : ^i_data;
        end
      end
      TX_START: if (tx_tick) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_tick) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == BW'(p_data_bits - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = (p_parity != 0) ? TX_PARITY : TX_STOP;
        end else begin
          tx_bit_d = tx_bit_q + BW'(1);
        end
      end
      TX_PARITY: if (tx_tick) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_tick) begin
        tx_cnt_d = '0;
        if (tx_bit_q == BW'(p_stop_bits - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_bit_d = tx_bit_q + BW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    o_accept = (tx_state_q == TX_IDLE) && !i_rst;
    unique case (tx_state_q)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift_q[0];
      TX_PARITY: tx_line = tx_par_q;
      default:   tx_line = 1'b1;
    endcase
  end

  assign o_tx = tx_line;

  // ---------------- RX ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  rx_state_e               rx_state_q, rx_state_d;
  logic [CW-1:0]           rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]           rx_bit_q, rx_bit_d;
  logic [p_data_bits-1:0]  rx_shift_q, rx_shift_d;
  logic                    rx_perr_q, rx_perr_d;
  logic                    rx_ferr_q, rx_ferr_d;
  logic                    loop_q, sync1_q, sync2_q, prev_q;
  logic                    rx_half, rx_full, rx_push;
  logic [FW-1:0]           rx_word;

  assign rx_half = (rx_cnt_q == CW'(CPB / 2 - 1));
  assign rx_full = (rx_cnt_q == CW'(CPB - 1));

  // Loop select only changes between frames so a frame never mixes sources.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      loop_q     <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      if (rx_state_q == RX_IDLE) loop_q <= i_loop;
      sync1_q    <= loop_q ? tx_line : i_rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d  = '0;
        rx_bit_d  = '0;
        rx_perr_d = 1'b0;
        rx_ferr_d = 1'b0;
        if (!sync2_q && prev_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_half) begin
        rx_cnt_d   = '0;
        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_full) begin
        rx_cnt_d   = '0;
        rx_shift_d = {sync2_q, rx_shift_q[p_data_bits-1:1]};
        if (rx_bit_q == BW'(p_data_bits - 1)) begin
          rx_bit_d   = '0;
          rx_state_d = (p_parity != 0) ? RX_PARITY : RX_STOP;
        end else begin
          rx_bit_d = rx_bit_q + BW'(1);
        end
      end
      RX_PARITY: if (rx_full) begin
        rx_cnt_d   = '0;
        rx_perr_d  = (^{rx_shift_q, sync2_q}) ^ (p_parity == 2);
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_full) begin
        rx_cnt_d = '0;
        if (!sync2_q) rx_ferr_d = 1'b1;
        if (rx_bit_q == BW'(p_stop_bits - 1)) begin
          rx_bit_d   = '0;
          rx_state_d = RX_IDLE;
        end else begin
          rx_bit_d = rx_bit_q + BW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // The last stop sample is folded into ferr here so the push happens on the sample cycle.
  always_comb begin
    rx_push = (rx_state_q == RX_STOP) && rx_full && (rx_bit_q == BW'(p_stop_bits - 1));
    rx_word = {rx_ferr_q | ~sync2_q, rx_perr_q, rx_shift_q};
  end

  // ---------------- FIFO ----------------
  logic [FW-1:0] mem_q [p_depth];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, push_ok;
  logic [FW-1:0] head;

  always_comb begin
    full    = (level_q == (AW + 1)'(p_depth));
    pop     = (level_q != '0) && i_ready;
    push_ok = rx_push && (!full || pop);
    ovf_d   = rx_push && !push_ok;
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q;
    if (push_ok && !pop) level_d = level_q + (AW + 1)'(1);
    if (!push_ok && pop) level_d = level_q - (AW + 1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < p_depth; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) mem_q[wptr_q] <= rx_word;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign head       = mem_q[rptr_q];
  assign o_valid    = (level_q != '0);
  assign o_data     = head[p_data_bits-1:0];
  assign o_perr     = head[p_data_bits];
  assign o_ferr     = head[p_data_bits+1];
  assign o_overflow = ovf_q;
  assign o_level    = level_q;

endmodule
